fifo_rd_drain: RTL

- Read-side consumer for the asynchronous FIFO. Runs entirely in the rclk domain.
- Pops words from the FIFO read port (rinc/rdata/rempty) into a 2-entry output buffer.
- Presents the words downstream as a registered valid/ready stream, with synchronous flush and a pop counter for debug and scoreboarding.
- It is the reader counterpart to the write-side stimulus/driver logic.

---
 rtl/fifo_rd_drain_if.sv | 22 ++
 rtl/fifo_rd_drain.sv | 85 ++++++++
 2 files changed

// File: rtl/fifo_rd_drain_if.sv
// FIFO read port plus downstream valid/ready stream for the read-side drain.
// master = the drain block, slave = FIFO/downstream environment.
interface fifo_rd_drain_if #(
  parameter int DATA = 8
);
  logic            rempty;
  logic [DATA-1:0] rdata;
  logic            rinc;
  logic            m_valid;
  logic [DATA-1:0] m_data;
  logic            m_ready;

  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-side consumer for the async FIFO: pops words into a 2-entry buffer and
// presents them as a registered valid/ready stream with flush and a pop counter.
module fifo_rd_drain #(
  parameter int DATA  = 8,
  parameter int CNT_W = 16
) (
  input  logic               rclk,
  input  logic               rrst,
  fifo_rd_drain_if.master    bus,
  input  logic               flush,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   rd_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [DATA-1:0] slot0, slot0_n;
  logic [DATA-1:0] slot1, slot1_n;
  logic            m_fire;
  logic            push;

  // A pop into a full buffer is only legal when the head leaves the same cycle.
  assign bus.m_valid = (state != EMPTY) && !flush;
  assign m_fire      = bus.m_valid && bus.m_ready;
  assign push        = !rrst && !bus.rempty && !flush && ((state != FULL2) || m_fire);
  assign bus.rinc    = push;
  assign bus.m_data  = slot0;
  assign occupancy   = state;

  always_comb begin
    state_n = state;
    slot0_n = slot0;
    slot1_n = slot1;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state_n = ONE;
            slot0_n = bus.rdata;
          end
        end
        ONE: begin
          if (push && !m_fire) begin
            state_n = FULL2;
            slot1_n = bus.rdata;
          end else if (push && m_fire) begin
            slot0_n = bus.rdata;
          end else if (m_fire) begin
            state_n = EMPTY;
          end
        end
        FULL2: begin
          if (m_fire) begin
            slot0_n = slot1;
            if (push) slot1_n = bus.rdata;
            else      state_n = ONE;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state    <= EMPTY;
      slot0    <= '0;
      slot1    <= '0;
      rd_count <= '0;
    end else begin
      state <= state_n;
      slot0 <= slot0_n;
      slot1 <= slot1_n;
      if (push) rd_count <= rd_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
